// File: rtl/rr_mux_arbiter4_pkg.sv
// Shared types and constants for the 4-way round-robin result-path arbiter.
package rr_mux_arbiter4_pkg;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned WIDTH_DEF  = 16;
  localparam int unsigned STALL_W    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // One-hot encoding of a requester index.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/Mux16_4.sv
// Generic 4:1 word multiplexer used on the shared result path.
module Mux16_4 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
module rr_pick4
  import rr_mux_arbiter4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   pick,
  output logic               any_req
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = SEL_W'(ptr + SEL_W'(k));
      if (!any_req && req[idx]) begin
        pick    = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter sharing one registered WIDTH-bit result path among four
// requesters, presented downstream with a VALID/READY handshake.
module rr_mux_arbiter4
  import rr_mux_arbiter4_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [WIDTH-1:0]   D0,
  input  logic [WIDTH-1:0]   D1,
  input  logic [WIDTH-1:0]   D2,
  input  logic [WIDTH-1:0]   D3,
  input  logic               READY,
  output logic [NUM_REQ-1:0] GNT,
  output logic [SEL_W-1:0]   SEL,
  output logic [WIDTH-1:0]   O,
  output logic               VALID,
  output logic               TIMEOUT
);

  localparam logic [STALL_W-1:0] STALL_MAX = '1;
  localparam logic [STALL_W-1:0] WAIT_LIM  = STALL_W'(MAX_WAIT);

  state_e               state, state_next;
  logic [SEL_W-1:0]     ptr;
  logic [STALL_W-1:0]   stall_cnt;
  logic [STALL_W-1:0]   stall_inc;
  logic [NUM_REQ-1:0]   req_elig;
  logic [SEL_W-1:0]     pick;
  logic                 any_req;
  logic [WIDTH-1:0]     mux_y;
  logic                 load;
  logic                 stall;

  // A requester granted this cycle may still hold REQ; keep it out of the search.
  assign req_elig = REQ & ~GNT;

  rr_pick4 u_pick (
    .req     (req_elig),
    .ptr     (ptr),
    .pick    (pick),
    .any_req (any_req)
  );

  Mux16_4 #(.WIDTH(WIDTH)) u_mux (
    .d0  (D0),
    .d1  (D1),
    .d2  (D2),
    .d3  (D3),
    .sel (pick),
    .y   (mux_y)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    stall      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (READY) begin
          load       = any_req;
          state_next = any_req ? BUSY : IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign stall_inc = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + STALL_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= '0;
      stall_cnt <= '0;
      GNT       <= '0;
      SEL       <= '0;
      O         <= '0;
      TIMEOUT   <= 1'b0;
    end else begin
      state <= state_next;
      GNT   <= load ? onehot4(pick) : '0;
      if (load) begin
        O   <= mux_y;
        SEL <= pick;
        ptr <= SEL_W'(pick + SEL_W'(1));
      end
      // Stall counter only runs while a word waits on READY; timeout is sticky.
      if (stall) begin
        stall_cnt <= stall_inc;
        if (stall_inc >= WAIT_LIM) TIMEOUT <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  assign VALID = (state == BUSY);

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Directed self-checking bench for rr_mux_arbiter4 (built with MAX_WAIT=3).
module tb_rr_mux_arbiter4;

  logic        CLK;
  logic        RST;
  logic [3:0]  REQ;
  logic [15:0] D0, D1, D2, D3;
  logic        READY;
  logic [3:0]  GNT;
  logic [1:0]  SEL;
  logic [15:0] O;
  logic        VALID;
  logic        TIMEOUT;

  int checks = 0;
  int errors = 0;

  rr_mux_arbiter4 #(.WIDTH(16), .MAX_WAIT(3)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ     (REQ),
    .D0      (D0),
    .D1      (D1),
    .D2      (D2),
    .D3      (D3),
    .READY   (READY),
    .GNT     (GNT),
    .SEL     (SEL),
    .O       (O),
    .VALID   (VALID),
    .TIMEOUT (TIMEOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] o,
                         input logic [1:0] s, input logic [3:0] g);
    chk({tag, ".valid"}, 32'(VALID), 32'(v));
    chk({tag, ".o"},     32'(O),     32'(o));
    chk({tag, ".sel"},   32'(SEL),   32'(s));
    chk({tag, ".gnt"},   32'(GNT),   32'(g));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REQ = 4'b0000;
    step();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; REQ = 4'b0000; READY = 1'b0;
    D0 = 16'h0; D1 = 16'h0; D2 = 16'h0; D3 = 16'h0;

    // Reset then single request
    step(); step();
    chk_out("reset", 1'b0, 16'h0000, 2'd0, 4'b0000);
    chk("reset.timeout", 32'(TIMEOUT), 32'd0);
    RST = 1'b0; REQ = 4'b0100; D2 = 16'hBEEF; READY = 1'b1;
    step();
    chk_out("single.cap", 1'b1, 16'hBEEF, 2'd2, 4'b0100);
    REQ = 4'b0000;
    step();
    chk_out("single.done", 1'b0, 16'hBEEF, 2'd2, 4'b0000);

    // Round-robin fairness, back-to-back
    do_reset();
    D0 = 16'h0000; D1 = 16'h0001; D2 = 16'h0002; D3 = 16'h0003;
    REQ = 4'b1111; READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("rr%0d", i), 1'b1, 16'(i % 4), 2'(i % 4), 4'(1 << (i % 4)));
    end
    REQ = 4'b0000;
    step();
    chk("rr.drain.valid", 32'(VALID), 32'd0);

    // Backpressure
    do_reset();
    D0 = 16'hAAAA; D1 = 16'h5555; REQ = 4'b0011; READY = 1'b0;
    step();
    chk_out("bp.cap", 1'b1, 16'hAAAA, 2'd0, 4'b0001);
    REQ = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("bp.stall%0d", i), 1'b1, 16'hAAAA, 2'd0, 4'b0000);
    end
    READY = 1'b1;
    step();
    chk_out("bp.next", 1'b1, 16'h5555, 2'd1, 4'b0010);
    REQ = 4'b0000;
    step();
    chk("bp.drain.valid", 32'(VALID), 32'd0);
    chk("bp.timeout", 32'(TIMEOUT), 32'd1);

    // Timeout
    do_reset();
    chk("to.cleared", 32'(TIMEOUT), 32'd0);
    D3 = 16'h1234; REQ = 4'b1000; READY = 1'b0;
    step();
    chk_out("to.cap", 1'b1, 16'h1234, 2'd3, 4'b1000);
    REQ = 4'b0000;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("to.flag%0d", i), 32'(TIMEOUT), 32'(i >= 3));
      chk($sformatf("to.o%0d", i), 32'(O), 32'h1234);
    end
    READY = 1'b1;
    step();
    chk("to.deliv.valid", 32'(VALID), 32'd0);
    chk("to.deliv.o", 32'(O), 32'h1234);
    chk("to.sticky", 32'(TIMEOUT), 32'd1);
    step();
    chk("to.sticky2", 32'(TIMEOUT), 32'd1);

    // Held-REQ masking
    do_reset();
    chk("mask.rst.timeout", 32'(TIMEOUT), 32'd0);
    D0 = 16'h7777; REQ = 4'b0001; READY = 1'b1;
    step();
    chk_out("mask.e1", 1'b1, 16'h7777, 2'd0, 4'b0001);
    step();
    chk_out("mask.e2", 1'b0, 16'h7777, 2'd0, 4'b0000);
    step();
    chk_out("mask.e3", 1'b1, 16'h7777, 2'd0, 4'b0001);
    REQ = 4'b0000;
    step();

    // Reset mid-transfer
    D2 = 16'h2222; REQ = 4'b0100; READY = 1'b0;
    step();
    chk_out("mid.cap", 1'b1, 16'h2222, 2'd2, 4'b0100);
    REQ = 4'b0000;
    step();
    RST = 1'b1;
    step();
    chk_out("mid.rst", 1'b0, 16'h0000, 2'd0, 4'b0000);
    RST = 1'b0;
    D1 = 16'h1111; D3 = 16'h3333; REQ = 4'b1010; READY = 1'b1;
    step();
    chk_out("mid.first", 1'b1, 16'h1111, 2'd1, 4'b0010);
    REQ = 4'b1000;
    step();
    chk_out("mid.second", 1'b1, 16'h3333, 2'd3, 4'b1000);
    REQ = 4'b0000;
    step();
    chk("mid.drain.valid", 32'(VALID), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
